// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and write-request type.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wr;
    logic [REG_DATA_W-1:0] wd;
  } rf_wr_req_t;
endpackage

// File: rtl/rf_arb_pick.sv
// rf_arb_pick: combinational grant selection; round-robin when RF_ARB_RR_EN is defined,
// otherwise fixed priority to port 0 with a starvation override for port 1.
module rf_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       v0,
  input  logic       v1,
`ifdef RF_ARB_RR_EN
  input  logic       rr_last,
`else
  input  logic [3:0] starv_cnt,
`endif
  output logic       g0,
  output logic       g1
);
  logic pri1;
  always_comb begin
`ifdef RF_ARB_RR_EN
    pri1 = !rr_last;
`else
    pri1 = starv_cnt == 4'(STARVE_LIMIT);
`endif
    g1 = v1 && (!v0 || pri1);
    g0 = v0 && !g1;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between two requesters.
// Define RF_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_wr,
  input  logic [REG_DATA_W-1:0] req0_wd,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_wr,
  input  logic [REG_DATA_W-1:0] req1_wd,
  output logic                  req1_ready,
  output logic [REG_ADDR_W-1:0] WR,
  output logic [REG_DATA_W-1:0] WD,
  output logic                  RegWrite
);
  logic g0, g1;
  rf_wr_req_t win;
`ifdef RF_ARB_RR_EN
  logic rr_last;
  rf_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .v0(req0_valid), .v1(req1_valid), .rr_last(rr_last), .g0(g0), .g1(g1)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last <= 1'b1;
    else if (g0 || g1) rr_last <= g1;
`else
  logic [3:0] starv_cnt;
  rf_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .v0(req0_valid), .v1(req1_valid), .starv_cnt(starv_cnt), .g0(g0), .g1(g1)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) starv_cnt <= '0;
    else if (!req1_valid || g1) starv_cnt <= '0;
    else if (starv_cnt != 4'(STARVE_LIMIT)) starv_cnt <= starv_cnt + 4'd1;
`endif
  assign req0_ready = g0 && !rst;
  assign req1_ready = g1 && !rst;
  assign win = g1 ? rf_wr_req_t'{req1_wr, req1_wd} : rf_wr_req_t'{req0_wr, req0_wd};
  // Register-0 writes still handshake and load WR/WD, but never raise RegWrite.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      RegWrite <= 1'b0;
      WR <= '0;
      WD <= '0;
    end else begin
      RegWrite <= (g0 || g1) && win.wr != ZERO_REG;
      if (g0 || g1) {WR, WD} <= win;
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of the write-port arbiter with a bench-side register file.
module tb_rf_write_arbiter;
  import rf_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready, RegWrite;
  logic [REG_ADDR_W-1:0] req0_wr, req1_wr, WR;
  logic [REG_DATA_W-1:0] req0_wd, req1_wd, WD;
  bit [REG_DATA_W-1:0] rf [NUM_REGS];
  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_wd(req0_wd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_wd(req1_wd), .req1_ready(req1_ready),
    .WR(WR), .WD(WD), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (RegWrite === 1'b1) rf[WR] <= WD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_wr = '0; req0_wd = '0;
    req1_valid = 1'b0; req1_wr = '0; req1_wd = '0;
    #1;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    repeat (2) tick;
    rst = 1'b0;
    #1;
    chk("rst_wr", 32'(WR), 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    tick;
    // single port-0 write
    req0_valid = 1'b1; req0_wr = 5'd5; req0_wd = 32'hDEAD_BEEF;
    #1;
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    tick;
    chk("t1_regwrite", 32'(RegWrite), 32'd1);
    chk("t1_wr", 32'(WR), 32'd5);
    chk("t1_wd", WD, 32'hDEAD_BEEF);
    req0_valid = 1'b0;
    tick;
    chk("t1_regwrite_idle", 32'(RegWrite), 32'd0);
    chk("t1_wr_hold", 32'(WR), 32'd5);
    chk("t1_rf5", rf[5], 32'hDEAD_BEEF);
    // conflict: port 0 first, port 1 next cycle
    req0_valid = 1'b1; req0_wr = 5'd3; req0_wd = 32'd1;
    req1_valid = 1'b1; req1_wr = 5'd4; req1_wd = 32'd2;
    #1;
    chk("t2_ready0", 32'(req0_ready), 32'd1);
    chk("t2_ready1", 32'(req1_ready), 32'd0);
    tick;
    chk("t2_wr_a", 32'(WR), 32'd3);
    chk("t2_wd_a", WD, 32'd1);
    chk("t2_rw_a", 32'(RegWrite), 32'd1);
    req0_valid = 1'b0;
    #1;
    chk("t2_ready1_b", 32'(req1_ready), 32'd1);
    tick;
    chk("t2_wr_b", 32'(WR), 32'd4);
    chk("t2_wd_b", WD, 32'd2);
    chk("t2_rw_b", 32'(RegWrite), 32'd1);
    req1_valid = 1'b0;
    tick;
    chk("t2_rf3", rf[3], 32'd1);
    chk("t2_rf4", rf[4], 32'd2);
    chk("t2_rw_idle", 32'(RegWrite), 32'd0);
`ifndef RF_ARB_RR_EN
    // starvation: port 1 wins on its fifth waiting cycle, twice in a row
    req0_valid = 1'b1; req0_wr = 5'd7; req0_wd = 32'h70;
    for (int r = 0; r < 2; r++) begin
      req1_valid = 1'b1; req1_wr = 5'd9; req1_wd = 32'h90;
      for (int i = 0; i < 5; i++) begin
        #1;
        chk("t3_ready1", 32'(req1_ready), (i == 4) ? 32'd1 : 32'd0);
        chk("t3_ready0", 32'(req0_ready), (i == 4) ? 32'd0 : 32'd1);
        tick;
        chk("t3_wr", 32'(WR), (i == 4) ? 32'd9 : 32'd7);
      end
      req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    tick;
`endif
    // write to register 0 is dropped
    req0_valid = 1'b1; req0_wr = 5'd0; req0_wd = 32'h1234;
    #1;
    chk("t4_ready0", 32'(req0_ready), 32'd1);
    tick;
    chk("t4_regwrite", 32'(RegWrite), 32'd0);
    chk("t4_wd", WD, 32'h1234);
    req0_valid = 1'b0;
    tick;
    chk("t4_rf0", rf[0], 32'd0);
    // reset after acceptance discards the pending write
    req0_valid = 1'b1; req0_wr = 5'd6; req0_wd = 32'h55;
    tick;
    chk("t5_rw_pre", 32'(RegWrite), 32'd1);
    req0_wr = 5'd8; req0_wd = 32'h88;
    rst = 1'b1;
    #1;
    chk("t5_rw_async", 32'(RegWrite), 32'd0);
    chk("t5_wr", 32'(WR), 32'd0);
    chk("t5_wd", WD, 32'd0);
    chk("t5_ready0_rst", 32'(req0_ready), 32'd0);
    tick;
    rst = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("t5_rw_post", 32'(RegWrite), 32'd0);
    chk("t5_wr_post", 32'(WR), 32'd0);
    tick;
    chk("t5_rf6", rf[6], 32'd0);
`ifdef RF_ARB_RR_EN
    // round-robin alternation, starting with port 0 after reset
    req0_valid = 1'b1; req0_wr = 5'd10; req0_wd = 32'hA;
    req1_valid = 1'b1; req1_wr = 5'd11; req1_wd = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between two writeback requesters: port 0 for ALU results and port 1 for load/multi-cycle results. Accepts at most one request per cycle through a valid/ready handshake and registers the winner onto the register-file write port (WR/WD/RegWrite). Writes to register 0 are always dropped. Port 1 cannot be starved indefinitely.

## Interface
- STARVE_LIMIT, default 4: consecutive lost cycles after which port 1 wins (range 1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  port 0 has a write pending.
- req0_wr  in  5  port 0 destination register.
- req0_wd  in  32  port 0 write data.
- req0_ready  out  1  port 0 accepted this cycle (combinational).
- req1_valid / req1_wr / req1_wd / req1_ready: same as port 0, for port 1.
- WR  out  5  register-file write address (registered).
- WD  out  32  register-file write data (registered).
- RegWrite  out  1  register-file write enable (registered).

## Operation
- Handshake: a transfer occurs when valid && ready. Once valid is asserted, the requester holds valid, wr and wd stable until ready is seen.
- Grant, fixed-priority mode (default):
  - Port 0 wins unless starv_cnt == STARVE_LIMIT; in that case port 1 wins.
  - A lone valid request always wins.
  - Exactly one ready is high when any valid is high.
- starv_cnt (4 bits, saturating at STARVE_LIMIT):
  - +1 each cycle req1_valid && !req1_ready.
  - Cleared when port 1 is granted or req1_valid is low.
- Output stage: on a grant, WR/WD load the winner's wr/wd on the next edge. RegWrite loads 1 if wr != 0, else 0.
  - A register-0 request still completes its handshake.
  - No grant: RegWrite loads 0; WR/WD hold their values.
- Same-register collision: the arbiter does not reorder or merge. The later-granted write lands last. Ordering between ports is the requesters' responsibility.
- Reset values: RegWrite=0, WR=0, WD=0, starv_cnt=0, rr_last=1. req0_ready and req1_ready are forced 0 while rst is high.
- Reset mid-operation: a registered write not yet applied is discarded (RegWrite drops asynchronously). Requesters must re-present any request not handshaken before reset.

## Timing
- Accept in cycle N → RegWrite/WR/WD valid throughout cycle N+1 → register-file array updated at the end of N+1 → readable on the combinational read ports from N+2.
- Throughput: one write per cycle sustained. The loser of a conflict waits at least one cycle.
- Fixed-priority worst case for port 1 under continuous port-0 traffic: granted on cycle STARVE_LIMIT+1 of waiting.
- ready depends combinationally on both valids and on the state registers. There is no combinational path from WD or WR back to ready.

## Configuration
- RF_ARB_RR_EN defined: round-robin replaces fixed priority and the starvation logic is compiled out.
  - On conflict, grant the port != rr_last.
  - rr_last updates to the granted port on every grant.
  - STARVE_LIMIT is ignored.
- RF_ARB_RR_EN undefined: fixed priority with the starvation counter as described under Operation.

## Structure
- Shared package rf_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG=5'd0.
  - typedef rf_wr_req_t {wr, wd}.
- One sub-module, rf_arb_pick: pure combinational grant selection from the two valids, starv_cnt/rr_last and the mode. The parent owns all flops.

## Test plan
- Single port-0 request wr=5, wd=32'hDEAD_BEEF → req0_ready=1 the same cycle. Next cycle RegWrite=1, WR=5, WD=32'hDEAD_BEEF. Register 5 reads 32'hDEAD_BEEF two cycles after acceptance.
- Both valid for one cycle (port 0 wr=3 wd=1, port 1 wr=4 wd=2) → port 0 granted first, port 1 next cycle. Two consecutive RegWrite pulses, to register 3 then register 4.
- Port 0 continuously valid, port 1 valid from cycle 0 with STARVE_LIMIT=4 → port 1 granted in cycle 4. starv_cnt returns to 0 afterwards.
- Request with wr=0, wd=32'h1234 → handshake completes, RegWrite stays 0, register 0 unchanged.
- rst asserted in the cycle after acceptance → RegWrite drops immediately, no array update. After release, all outputs match their reset values.
- With RF_ARB_RR_EN defined, both ports continuously valid → grants alternate 0,1,0,1 starting with port 0.
